// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types : shared word/line types and helpers for the LC-3b cache levels.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_line;

  localparam lc3b_word c_CNT_MAX = 16'hFFFF;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic lc3b_word sat_inc(input lc3b_word val);
    return (val == c_CNT_MAX) ? val : val + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_vc_requester.sv
// ---------------------------------------------------------------------------
// l2_vc_requester : services an L2 miss from the victim cache or main memory,
//                   then writes the L2 victim into the victim cache.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l2_vc_requester
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     l2_req,
  input  lc3b_word l2_addr,
  input  logic     victim_valid,
  input  lc3b_word victim_addr,
  input  lc3b_line victim_data,
  input  logic     victim_dirty,
  output logic     fill_valid,
  output lc3b_line fill_data,
  output logic     fill_dirty,
  output logic     busy,
  output logic     vc_read,
  output logic     vc_write,
  output lc3b_word vc_addr,
  output lc3b_line vc_wdata,
  output logic     vc_wdirty,
  input  logic     vc_resp,
  input  logic     vc_hit,
  input  lc3b_line vc_rdata,
  input  logic     vc_rdirty,
  output logic     pmem_read,
  output lc3b_word pmem_address,
  input  logic     pmem_resp,
  input  lc3b_line pmem_rdata,
  output lc3b_word hit_count,
  output lc3b_word miss_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VC_READ   = 3'd1,
    S_PMEM_READ = 3'd2,
    S_VC_WRITE  = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e   state_q, state_d;
  lc3b_word addr_q, addr_d;
  logic     vvalid_q, vvalid_d;
  lc3b_word vaddr_q, vaddr_d;
  lc3b_line vdata_q, vdata_d;
  logic     vdirty_q, vdirty_d;
  lc3b_line fdata_q, fdata_d;
  logic     fdirty_q, fdirty_d;
  lc3b_word hit_q, hit_d;
  lc3b_word miss_q, miss_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    vvalid_d = vvalid_q;
    vaddr_d  = vaddr_q;
    vdata_d  = vdata_q;
    vdirty_d = vdirty_q;
    fdata_d  = fdata_q;
    fdirty_d = fdirty_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    case (state_q)
      S_IDLE: begin
        if (l2_req) begin
          addr_d   = l2_addr;
          vvalid_d = victim_valid;
          vaddr_d  = victim_addr;
          vdata_d  = victim_data;
          vdirty_d = victim_dirty;
          state_d  = S_VC_READ;
        end
      end
      S_VC_READ: begin
        if (vc_resp) begin
          if (vc_hit) begin
            fdata_d  = vc_rdata;
            fdirty_d = vc_rdirty;
            hit_d    = sat_inc(hit_q);
            state_d  = vvalid_q ? S_VC_WRITE : S_DONE;
          end else begin
            miss_d  = sat_inc(miss_q);
            state_d = S_PMEM_READ;
          end
        end
      end
      S_PMEM_READ: begin
        if (pmem_resp) begin
          fdata_d  = pmem_rdata;
          fdirty_d = 1'b0;
          state_d  = vvalid_q ? S_VC_WRITE : S_DONE;
        end
      end
      S_VC_WRITE: begin
        if (vc_resp) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      vvalid_q <= 1'b0;
      vaddr_q  <= '0;
      vdata_q  <= '0;
      vdirty_q <= 1'b0;
      fdata_q  <= '0;
      fdirty_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      vvalid_q <= vvalid_d;
      vaddr_q  <= vaddr_d;
      vdata_q  <= vdata_d;
      vdirty_q <= vdirty_d;
      fdata_q  <= fdata_d;
      fdirty_q <= fdirty_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Outputs decode only from state and latched fields, never from l2_* inputs.
  assign busy         = (state_q != S_IDLE);
  assign fill_valid   = (state_q == S_DONE);
  assign fill_data    = fdata_q;
  assign fill_dirty   = fdirty_q;
  assign vc_read      = (state_q == S_VC_READ);
  assign vc_write     = (state_q == S_VC_WRITE);
  assign vc_addr      = (state_q == S_VC_WRITE) ? vaddr_q : addr_q;
  assign vc_wdata     = vdata_q;
  assign vc_wdirty    = vdirty_q;
  assign pmem_read    = (state_q == S_PMEM_READ);
  assign pmem_address = addr_q;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_vc_requester.sv
// ---------------------------------------------------------------------------
// tb_l2_vc_requester : directed scoreboard bench for l2_vc_requester.
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_l2_vc_requester;

  logic         clk, rst, l2_req, victim_valid, victim_dirty;
  logic [15:0]  l2_addr, victim_addr;
  logic [255:0] victim_data;
  logic         fill_valid, fill_dirty, busy, vc_read, vc_write, vc_wdirty;
  logic [255:0] fill_data, vc_wdata, vc_rdata, pmem_rdata;
  logic [15:0]  vc_addr, pmem_address, hit_count, miss_count;
  logic         vc_resp, vc_hit, vc_rdirty, pmem_read, pmem_resp;

  typedef struct {
    logic [255:0] data;
    logic         dirty;
    logic [15:0]  hit;
    logic [15:0]  miss;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_hit, exp_miss;
  int          checks, errors;

  l2_vc_requester dut (
    .clk(clk), .rst(rst), .l2_req(l2_req), .l2_addr(l2_addr),
    .victim_valid(victim_valid), .victim_addr(victim_addr),
    .victim_data(victim_data), .victim_dirty(victim_dirty),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_dirty(fill_dirty),
    .busy(busy), .vc_read(vc_read), .vc_write(vc_write), .vc_addr(vc_addr),
    .vc_wdata(vc_wdata), .vc_wdirty(vc_wdirty), .vc_resp(vc_resp),
    .vc_hit(vc_hit), .vc_rdata(vc_rdata), .vc_rdirty(vc_rdirty),
    .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scoreboard monitor: every fill strobe consumes one expected entry.
  always @(negedge clk) begin
    chk("rd_wr_exclusive", vc_read & vc_write, 0);
    chk("pmem_vc_exclusive", pmem_read & (vc_read | vc_write), 0);
    if (fill_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fill", fill_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fill_data", fill_data, e.data);
        chk("fill_dirty", fill_dirty, e.dirty);
        chk("hit_count", hit_count, e.hit);
        chk("miss_count", miss_count, e.miss);
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic txn(input logic [15:0] a, input logic vv, input logic [15:0] va,
                     input logic [255:0] vd, input logic vdi, input logic hit,
                     input int vlat, input logic [255:0] rd, input logic rdi,
                     input int plat, input logic [255:0] pd, input int wlat);
    exp_t e;
    if (hit) exp_hit = sat(exp_hit);
    else     exp_miss = sat(exp_miss);
    e.data  = hit ? rd : pd;
    e.dirty = hit ? rdi : 1'b0;
    e.hit   = exp_hit;
    e.miss  = exp_miss;
    exp_q.push_back(e);
    l2_req = 1'b1; l2_addr = a; victim_valid = vv;
    victim_addr = va; victim_data = vd; victim_dirty = vdi;
    @(posedge clk); #1;
    // Inputs scrambled after acceptance must not affect the transaction.
    l2_addr = ~a; victim_valid = ~vv; victim_addr = ~va;
    victim_data = ~vd; victim_dirty = ~vdi;
    for (int i = 0; i < vlat; i++) begin
      vc_resp = (i == vlat - 1); vc_hit = hit; vc_rdata = rd; vc_rdirty = rdi;
      pmem_resp = (i != vlat - 1);
      @(negedge clk);
      chk("busy_vcrd", busy, 1);
      chk("vc_read", vc_read, 1);
      chk("vc_addr_rd", vc_addr, a);
      chk("pmem_in_vcrd", pmem_read, 0);
      @(posedge clk); #1;
    end
    vc_resp = 1'b0; pmem_resp = 1'b0;
    if (!hit) begin
      for (int i = 0; i < plat; i++) begin
        vc_resp = (i != plat - 1); vc_hit = 1'b1;
        pmem_resp = (i == plat - 1); pmem_rdata = pd;
        @(negedge clk);
        chk("pmem_read", pmem_read, 1);
        chk("pmem_address", pmem_address, a);
        chk("vc_in_pmem", vc_read | vc_write, 0);
        @(posedge clk); #1;
      end
      vc_resp = 1'b0; pmem_resp = 1'b0;
    end
    if (vv) begin
      for (int i = 0; i < wlat; i++) begin
        vc_resp = (i == wlat - 1); pmem_resp = (i != wlat - 1);
        @(negedge clk);
        chk("vc_write", vc_write, 1);
        chk("vc_addr_wr", vc_addr, va);
        chk("vc_wdata", vc_wdata, vd);
        chk("vc_wdirty", vc_wdirty, vdi);
        chk("rd_in_write", vc_read | pmem_read, 0);
        @(posedge clk); #1;
      end
      vc_resp = 1'b0; pmem_resp = 1'b0;
    end
    @(negedge clk);
    chk("fill_valid_done", fill_valid, 1);
    @(posedge clk); #1;
    l2_req = 1'b0;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("fill_once", fill_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] lineA, lineB, lineC, lineD, lineE;
    checks = 0; errors = 0; exp_hit = 16'd0; exp_miss = 16'd0;
    lineA = {8{32'hA5A5_0001}}; lineB = {8{32'hB0B0_0002}};
    lineC = {8{32'hC3C3_0003}}; lineD = {8{32'hD00D_0004}};
    lineE = {8{32'hEEEE_0005}};
    rst = 1'b1; l2_req = 1'b0; l2_addr = '0; victim_valid = 1'b0;
    victim_addr = '0; victim_data = '0; victim_dirty = 1'b0;
    vc_resp = 1'b0; vc_hit = 1'b0; vc_rdata = '0; vc_rdirty = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {fill_valid, vc_read, vc_write, pmem_read}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    chk("rst_fill", {fill_data, fill_dirty}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // VC hit on 2nd cycle, no victim.
    txn(16'h1A40, 1'b0, 16'h0, '0, 1'b0, 1'b1, 2, lineA, 1'b1, 0, '0, 0);
    // VC miss, dirty victim, pmem responds in 5th cycle.
    txn(16'h3C00, 1'b1, 16'h0200, lineC, 1'b1, 1'b0, 1, lineE, 1'b1, 5, lineB, 2);

    // Spurious responses while idle.
    vc_resp = 1'b1; vc_hit = 1'b1; pmem_resp = 1'b1;
    @(posedge clk); #1;
    vc_resp = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    chk("spur_busy", busy, 0);
    chk("spur_counts", {hit_count, miss_count}, {exp_hit, exp_miss});
    @(posedge clk); #1;
    // Hit with a clean victim; pmem_resp pulses while VC_READ waits.
    txn(16'h7777, 1'b1, 16'h0888, lineD, 1'b0, 1'b1, 3, lineE, 1'b0, 0, '0, 1);

    // Reset in the middle of PMEM_READ.
    l2_req = 1'b1; l2_addr = 16'h0444; victim_valid = 1'b0;
    @(posedge clk); #1;
    vc_resp = 1'b1; vc_hit = 1'b0;
    @(posedge clk); #1;
    vc_resp = 1'b0;
    @(negedge clk);
    chk("pre_rst_pmem", pmem_read, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_hit = 16'd0; exp_miss = 16'd0;
    @(negedge clk);
    chk("mid_rst_pmem", pmem_read, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_counts", {hit_count, miss_count}, 0);
    chk("mid_rst_fill", {fill_data, fill_dirty}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    txn(16'h0555, 1'b0, 16'h0, '0, 1'b0, 1'b0, 1, lineA, 1'b1, 2, lineD, 0);

    // Saturation from a preloaded hit count.
    @(negedge clk);
    force dut.hit_q = 16'hFFFE;
    #2;
    release dut.hit_q;
    exp_hit = 16'hFFFE;
    @(negedge clk);
    chk("preload_hit", hit_count, 16'hFFFE);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      txn(16'h2000 + 16'(k), 1'b0, 16'h0, '0, 1'b0, 1'b1, 1, lineB, k[0], 0, '0, 0);
    @(negedge clk);
    chk("sat_hit", hit_count, 16'hFFFF);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
